// File: rtl/jk_excitation_gen.sv
// J/K excitation generator: turns a FIFO of target words into per-bit J/K drive for a JK bank.
// Optional build macro JKGEN_TOGGLE_EN selects toggle (J=K=1) encoding for changing bits.
module jk_excitation_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_target,
    input  logic                     jk_en,
    input  logic                     sync_valid,
    input  logic [WIDTH-1:0]         sync_q,
    output logic [WIDTH-1:0]         J,
    output logic [WIDTH-1:0]         K,
    output logic                     jk_valid,
    output logic [WIDTH-1:0]         q_model,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         trans_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned PC_W   = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W  = CNT_W + PC_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             push;
    logic             issue;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] diff;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;

    // No full-cycle bypass: a full FIFO refuses input even while popping.
    assign in_ready = (fifo_count != FCNT_W'(DEPTH));

    always_comb begin
        push     = in_valid & in_ready;
        issue    = jk_en & (fifo_count != '0) & ~sync_valid;
        head     = mem[rd_ptr];
        diff     = q_model ^ head;
        pc       = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(diff[i]);
        end
        sum      = SUM_W'(trans_cnt) + SUM_W'(pc);
        cnt_next = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
`ifdef JKGEN_TOGGLE_EN
        j_next   = diff;
        k_next   = diff;
`else
        j_next   = ~q_model & head;
        k_next   = q_model & ~head;
`endif
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= in_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            J          <= '0;
            K          <= '0;
            jk_valid   <= 1'b0;
            q_model    <= '0;
            trans_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            J        <= '0;
            K        <= '0;
            jk_valid <= 1'b0;
            if (sync_valid) begin
                q_model <= sync_q;
            end else if (issue) begin
                J         <= j_next;
                K         <= k_next;
                jk_valid  <= 1'b1;
                q_model   <= head;
                trans_cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_gen.sv
// Self-checking bench for jk_excitation_gen: queue-based model checked every cycle plus directed literals.
module tb_jk_excitation_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_target;
    logic             jk_en;
    logic             sync_valid;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] J, K, q_model;
    logic             jk_valid;
    logic [2:0]       fifo_count;
    logic [15:0]      trans_cnt;

    logic             s_in_ready, s_jk_valid;
    logic [WIDTH-1:0] s_J, s_K, s_q_model;
    logic [2:0]       s_fifo_count;
    logic [3:0]       s_trans_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_excitation_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_target(in_target), .jk_en(jk_en), .sync_valid(sync_valid), .sync_q(sync_q),
        .J(J), .K(K), .jk_valid(jk_valid), .q_model(q_model),
        .fifo_count(fifo_count), .trans_cnt(trans_cnt)
    );

    // Narrow-counter instance shares stimulus to exercise saturation.
    jk_excitation_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_target(in_target), .jk_en(jk_en), .sync_valid(sync_valid), .sync_q(sync_q),
        .J(s_J), .K(s_K), .jk_valid(s_jk_valid), .q_model(s_q_model),
        .fifo_count(s_fifo_count), .trans_cnt(s_trans_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending targets and the bank state it implies.
    logic [WIDTH-1:0] fifo_m[$];
    logic [WIDTH-1:0] mq, ej, ek, t;
    logic             ev;
    int               mc16, mc4, pc;
    bit               armed = 1'b0;
    bit               do_push, do_issue;

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            fifo_m.delete();
            mq = '0; ej = '0; ek = '0; ev = 1'b0; mc16 = 0; mc4 = 0;
        end else begin
            do_push  = in_valid && (fifo_m.size() != DEPTH);
            do_issue = jk_en && (fifo_m.size() != 0) && !sync_valid;
            ej = '0; ek = '0; ev = 1'b0;
            if (sync_valid) begin
                mq = sync_q;
            end else if (do_issue) begin
                t = fifo_m.pop_front();
                for (int i = 0; i < WIDTH; i++) begin
                    case ({mq[i], t[i]})
`ifdef JKGEN_TOGGLE_EN
                        2'b01, 2'b10: begin ej[i] = 1'b1; ek[i] = 1'b1; end
`else
                        2'b01: ej[i] = 1'b1;
                        2'b10: ek[i] = 1'b1;
`endif
                        default: ;
                    endcase
                end
                pc   = $countones(mq ^ t);
                mc16 = (mc16 + pc > 65535) ? 65535 : mc16 + pc;
                mc4  = (mc4 + pc > 15) ? 15 : mc4 + pc;
                mq   = t;
                ev   = 1'b1;
            end
            if (do_push) fifo_m.push_back(in_target);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("m_J", 32'(J), 32'(ej));
            check("m_K", 32'(K), 32'(ek));
            check("m_jk_valid", 32'(jk_valid), 32'(ev));
            check("m_q_model", 32'(q_model), 32'(mq));
            check("m_fifo_count", 32'(fifo_count), 32'(fifo_m.size()));
            check("m_in_ready", 32'(in_ready), 32'(fifo_m.size() != DEPTH));
            check("m_trans_cnt", 32'(trans_cnt), 32'(mc16));
            check("m_trans_cnt_w4", 32'(s_trans_cnt), 32'(mc4));
            check("m_w4_q_model", 32'(s_q_model), 32'(mq));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_target = 8'h55;
        jk_en = 1'b0; sync_valid = 1'b0; sync_q = '0;

        // Reset held with in_valid high: nothing may be pushed.
        tick(); tick();
        check("rst_J", 32'(J), 32'h0);
        check("rst_K", 32'(K), 32'h0);
        check("rst_jk_valid", 32'(jk_valid), 32'h0);
        check("rst_q_model", 32'(q_model), 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_trans_cnt", 32'(trans_cnt), 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Two words, jk_en held high.
        jk_en = 1'b1; in_valid = 1'b1; in_target = 8'hA5;
        tick();
        check("first_not_yet", 32'(jk_valid), 32'h0);
        in_target = 8'h0F;
        tick();
`ifdef JKGEN_TOGGLE_EN
        check("a5_J", 32'(J), 32'hA5);
        check("a5_K", 32'(K), 32'hA5);
`else
        check("a5_J", 32'(J), 32'hA5);
        check("a5_K", 32'(K), 32'h00);
`endif
        check("a5_q", 32'(q_model), 32'hA5);
        in_valid = 1'b0;
        tick();
`ifdef JKGEN_TOGGLE_EN
        check("0f_J", 32'(J), 32'hAA);
        check("0f_K", 32'(K), 32'hAA);
`else
        check("0f_J", 32'(J), 32'h0A);
        check("0f_K", 32'(K), 32'hA0);
`endif
        check("0f_q", 32'(q_model), 32'h0F);
        check("0f_cnt", 32'(trans_cnt), 32'd8);
        tick();
        check("empty_valid", 32'(jk_valid), 32'h0);
        check("empty_J", 32'(J), 32'h0);

        // Fill to DEPTH with jk_en low; fifth word waits.
        jk_en = 1'b0; in_valid = 1'b1;
        in_target = 8'h11; tick();
        in_target = 8'h22; tick();
        in_target = 8'h33; tick();
        in_target = 8'h44; tick();
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(in_ready), 32'h0);
        in_target = 8'h55; tick();
        check("full_hold", 32'(fifo_count), 32'd4);
        jk_en = 1'b1; tick();
        check("drain_11", 32'(q_model), 32'h11);
        check("drain_cnt3", 32'(fifo_count), 32'd3);
        tick();
        in_valid = 1'b0;
        check("drain_22", 32'(q_model), 32'h22);
        check("pushpop_cnt", 32'(fifo_count), 32'd3);
        tick(); tick(); tick();
        check("drain_55", 32'(q_model), 32'h55);
        check("drain_empty", 32'(fifo_count), 32'd0);

        // Resync to 0x0F, queue 0x00, then a sync cycle suppresses the issue.
        jk_en = 1'b0; sync_valid = 1'b1; sync_q = 8'h0F; tick();
        check("sync_q0f", 32'(q_model), 32'h0F);
        sync_valid = 1'b0; in_valid = 1'b1; in_target = 8'h00; tick();
        in_valid = 1'b0; jk_en = 1'b1; sync_valid = 1'b1; sync_q = 8'hFF; tick();
        check("sync_noissue", 32'(jk_valid), 32'h0);
        check("sync_qff", 32'(q_model), 32'hFF);
        check("sync_noflush", 32'(fifo_count), 32'd1);
        sync_valid = 1'b0; tick();
`ifdef JKGEN_TOGGLE_EN
        check("sync_J", 32'(J), 32'hFF);
`else
        check("sync_J", 32'(J), 32'h00);
`endif
        check("sync_K", 32'(K), 32'hFF);
        check("sync_q00", 32'(q_model), 32'h00);

        // 0x0F -> 0x3C encoding.
        jk_en = 1'b0; sync_valid = 1'b1; sync_q = 8'h0F; tick();
        sync_valid = 1'b0; in_valid = 1'b1; in_target = 8'h3C; tick();
        in_valid = 1'b0; jk_en = 1'b1; tick();
`ifdef JKGEN_TOGGLE_EN
        check("tog_J", 32'(J), 32'h33);
        check("tog_K", 32'(K), 32'h33);
`else
        check("tog_J", 32'(J), 32'h30);
        check("tog_K", 32'(K), 32'h03);
`endif

        // Alternate 0x00/0xFF to saturate the narrow counter.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_target = (i % 2 == 0) ? 8'h00 : 8'hFF;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        check("sat_w4", 32'(s_trans_cnt), 32'hF);

        // Reset mid-operation discards buffered targets.
        jk_en = 1'b0; in_valid = 1'b1; in_target = 8'h77; tick();
        in_target = 8'h88; tick();
        in_valid = 1'b0; rst = 1'b1; tick();
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_q", 32'(q_model), 32'h0);
        rst = 1'b0; jk_en = 1'b1; tick();
        check("midrst_noissue", 32'(jk_valid), 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_excitation_gen.md
Name: jk_excitation_gen

Overview:
- Inverse of the JK flip-flop function. Accepts a stream of target state words and produces the per-bit J/K excitation that drives a WIDTH-bit bank of JK flip-flops to each target on successive enabled cycles.
- Keeps an internal model of the bank's Q, buffers targets in a small FIFO, and counts bit transitions issued.
- Sits between a pattern/sequence source and the JK flip-flop bank it controls.

Parameters:
- WIDTH, 8, number of JK flip-flops driven (bits per target word)
- DEPTH, 4, target FIFO entries; power of 2, minimum 2
- CNT_W, 16, width of the transition counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_target valid
- in_ready  output  1  FIFO can accept a word this cycle
- in_target  input  WIDTH  desired next state of the flip-flop bank
- jk_en  input  1  downstream bank samples J/K this cycle; issue allowed
- sync_valid  input  1  load model state from sync_q
- sync_q  input  WIDTH  actual bank state for resynchronisation
- J  output  WIDTH  J excitation, registered
- K  output  WIDTH  K excitation, registered
- jk_valid  output  1  J/K carry a new issued word this cycle
- q_model  output  WIDTH  modelled bank state after the last issued word
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy
- trans_cnt  output  CNT_W  saturating count of bits changed by issued words

Behaviour:
- Decided interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: J=0, K=0, jk_valid=0, q_model=0, trans_cnt=0, fifo_count=0, FIFO emptied. in_ready=1 once rst is deasserted.
- Reset mid-operation: all buffered targets are discarded. No J/K pulse is issued on the reset edge.
- Push: in_ready = (fifo_count != DEPTH).
  - A word is written on an edge where in_valid & in_ready.
  - in_ready is not raised when the FIFO is full, even if a pop occurs in the same cycle. No full-cycle bypass.
- Pop/issue: an issue occurs on an edge where jk_en=1, the FIFO is not empty, and sync_valid=0. On that edge:
  - The head word T is popped.
  - J, K are registered from (q_model, T) per bit.
  - q_model <= T.
  - jk_valid <= 1.
  - trans_cnt increases by popcount(q_model ^ T), saturating at all-ones.
- No issue: J <= 0, K <= 0 (bank holds), jk_valid <= 0. q_model and trans_cnt are unchanged.
- Excitation encoding, default (per bit, q -> t):
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->1: J=0, K=0
  - 1->0: J=0, K=1
  - Don't-cares are resolved to 0. J=K=1 is never emitted.
- Latency:
  - A word pushed on edge N is issuable on edge N+1 at earliest. J/K are visible from N+1 until the next edge.
  - Back-to-back issue with jk_en held high gives one word per cycle.
- Simultaneous push and pop (FIFO not full): both occur; fifo_count is unchanged.
- Empty FIFO with jk_en=1: no issue; outputs are zero.
- Sync: on an edge with sync_valid=1, q_model <= sync_q and issue is suppressed (J=K=0, jk_valid=0).
  - The FIFO is not flushed.
  - Pushes proceed normally.
  - trans_cnt is unchanged.
- Priority: rst > sync_valid > issue.
- FIFO pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: JKGEN_TOGGLE_EN
- Defined: every changing bit (0->1 or 1->0) is encoded as J=1, K=1 (toggle). Unchanged bits stay J=0, K=0. q_model and trans_cnt rules are unchanged.
- Undefined: the set/reset encoding above. J=K=1 never appears.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> J=K=0, jk_valid=0, q_model=0x00, fifo_count=0, trans_cnt=0; no push during reset.
- Push 0xA5, then 0x0F, with jk_en=1 continuously:
  - First issue: J=0xA5, K=0x00, q_model=0xA5.
  - Next cycle: J=0x0A, K=0xA0, q_model=0x0F, trans_cnt=4+4=8.
- Fill: jk_en=0, push 5 words with DEPTH=4 -> in_ready=0 after 4 pushes, fifo_count=4, fifth word held until jk_en=1 frees a slot; word order preserved.
- Sync: q_model=0x0F, sync_valid=1 with sync_q=0xFF while FIFO holds 0x00 and jk_en=1 -> no issue that cycle; next cycle J=0x00, K=0xFF, q_model=0x00.
- Saturation: CNT_W=4, alternate 0x00/0xFF targets -> trans_cnt stops at 0xF.
- Toggle build (JKGEN_TOGGLE_EN defined): q_model=0x0F, target 0x3C -> J=0x33, K=0x33.
